// File: rtl/mips_exec_pkg.sv
// Shared constants for the MIPS EX-stage slice: opcodes, funct codes,
// ALU operation encodings and control-word bit positions.
package mips_exec_pkg;

  typedef logic [3:0] alu_op_t;
  typedef logic [8:0] ctrl_word_t;

  // Opcodes, instruction bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_IN    = 6'b111100;
  localparam logic [5:0] OP_OUT   = 6'b111101;

  // Funct codes, instruction bits [5:0]
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation encodings
  localparam alu_op_t ALU_AND = 4'b0000;
  localparam alu_op_t ALU_OR  = 4'b0001;
  localparam alu_op_t ALU_ADD = 4'b0010;
  localparam alu_op_t ALU_XOR = 4'b0011;
  localparam alu_op_t ALU_SUB = 4'b0110;
  localparam alu_op_t ALU_SLT = 4'b0111;
  localparam alu_op_t ALU_NOR = 4'b1100;

  // Control-word bit positions
  localparam int CTRL_MEMTOREG = 8;
  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_BRANCH   = 6;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_REGDST   = 3;
  localparam int CTRL_ALUSRC   = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;

  // Assemble a control word from its named fields
  function automatic ctrl_word_t make_ctrl(
    input logic       memtoreg,
    input logic       regwrite,
    input logic       branch,
    input logic       memread,
    input logic       memwrite,
    input logic       regdst,
    input logic       alusrc,
    input logic [1:0] aluop
  );
    ctrl_word_t w;
    w = '0;
    w[CTRL_MEMTOREG] = memtoreg;
    w[CTRL_REGWRITE] = regwrite;
    w[CTRL_BRANCH]   = branch;
    w[CTRL_MEMREAD]  = memread;
    w[CTRL_MEMWRITE] = memwrite;
    w[CTRL_REGDST]   = regdst;
    w[CTRL_ALUSRC]   = alusrc;
    w[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = aluop;
    return w;
  endfunction

  localparam ctrl_word_t CTRL_RTYPE = make_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10);
  localparam ctrl_word_t CTRL_LOAD  = make_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
  localparam ctrl_word_t CTRL_STORE = make_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
  localparam ctrl_word_t CTRL_BRNCH = make_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
  localparam ctrl_word_t CTRL_IMM   = make_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);

endpackage

// File: rtl/mips_exec_ctrl_alu.sv
// Purely combinational 32-bit (DATA_W) ALU core. Add/sub wrap modulo
// 2^DATA_W; SLT is a signed compare; undefined operations return zero.
module mips_alu_core
  import mips_exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  alu_op_t           alu_con,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic [DATA_W-1:0] result
);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;

  assign a_s = signed'(src_a);
  assign b_s = signed'(src_b);

  // Select the operation result; unknown encodings give zero
  always_comb begin
    result = '0;
    case (alu_con)
      ALU_AND: result = src_a & src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_ADD: result = src_a + src_b;
      ALU_XOR: result = src_a ^ src_b;
      ALU_SUB: result = src_a - src_b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      ALU_NOR: result = ~(src_a | src_b);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mips_exec_ctrl.sv
// MIPS decode/execute slice: main control decoder, ALU control decoder,
// combinational ALU and a registered ALU result for the EX/MEM boundary.
// Optional build macro MIPS_EXEC_FLAGS_EN adds zero/ovf flags and their
// registered copies zero_q/ovf_q.
module mips_exec_ctrl
  import mips_exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [1:0]        aluop_in,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic [8:0]        ctrl,
  output logic              brne,
  output logic              breq,
  output logic              andi,
  output logic              ori,
  output logic              addi,
  output logic              subi,
  output logic              in_out,
  output logic [3:0]        alu_con,
  output logic [DATA_W-1:0] alu_out,
`ifdef MIPS_EXEC_FLAGS_EN
  output logic              zero,
  output logic              ovf,
  output logic              zero_q,
  output logic              ovf_q,
`endif
  output logic [DATA_W-1:0] alu_q
);

  logic [DATA_W-1:0] alu_p1;

  // Main decoder: opcode to control word and instruction-class flag
  always_comb begin
    ctrl   = '0;
    brne   = 1'b0;
    breq   = 1'b0;
    andi   = 1'b0;
    ori    = 1'b0;
    addi   = 1'b0;
    subi   = 1'b0;
    in_out = 1'b0;
    case (opcode)
      OP_RTYPE: ctrl = CTRL_RTYPE;
      OP_LW:    ctrl = CTRL_LOAD;
      OP_SW:    ctrl = CTRL_STORE;
      OP_BEQ:   begin ctrl = CTRL_BRNCH; breq = 1'b1; end
      OP_BNE:   begin ctrl = CTRL_BRNCH; brne = 1'b1; end
      OP_ADDI:  begin ctrl = CTRL_IMM;   addi = 1'b1; end
      OP_SUBI:  begin ctrl = CTRL_IMM;   subi = 1'b1; end
      OP_ANDI:  begin ctrl = CTRL_IMM;   andi = 1'b1; end
      OP_ORI:   begin ctrl = CTRL_IMM;   ori  = 1'b1; end
      OP_IN:    begin ctrl = CTRL_LOAD;  in_out = 1'b1; end
      OP_OUT:   begin ctrl = CTRL_STORE; in_out = 1'b1; end
      default:  ctrl = '0;
    endcase
  end

  // ALU control: ALUOp selects fixed add/sub, funct decode or immediate class
  always_comb begin
    alu_con = ALU_ADD;
    case (aluop_in)
      2'b00: alu_con = ALU_ADD;
      2'b01: alu_con = ALU_SUB;
      2'b10: begin
        case (funct)
          FN_ADD:  alu_con = ALU_ADD;
          FN_SUB:  alu_con = ALU_SUB;
          FN_AND:  alu_con = ALU_AND;
          FN_OR:   alu_con = ALU_OR;
          FN_XOR:  alu_con = ALU_XOR;
          FN_NOR:  alu_con = ALU_NOR;
          FN_SLT:  alu_con = ALU_SLT;
          default: alu_con = ALU_ADD;
        endcase
      end
      default: begin
        if (andi)      alu_con = ALU_AND;
        else if (ori)  alu_con = ALU_OR;
        else if (addi) alu_con = ALU_ADD;
        else if (subi) alu_con = ALU_SUB;
        else           alu_con = ALU_ADD;
      end
    endcase
  end

  mips_alu_core #(
    .DATA_W (DATA_W)
  ) u_alu (
    .alu_con (alu_con),
    .src_a   (src_a),
    .src_b   (src_b),
    .result  (alu_out)
  );

  // ---- EX/MEM boundary (p1) ----
  // Register the ALU result; reset clears it immediately
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) alu_p1 <= '0;
    else          alu_p1 <= alu_out;
  end

  assign alu_q = alu_p1;

`ifdef MIPS_EXEC_FLAGS_EN
  logic zero_p1;
  logic ovf_p1;

  // Signed overflow: operands agree in sign (add) or differ (sub) and the
  // result sign departs from operand A
  always_comb begin
    zero = (alu_out == '0);
    ovf  = 1'b0;
    if (alu_con == ALU_ADD)
      ovf = (src_a[DATA_W-1] == src_b[DATA_W-1]) && (alu_out[DATA_W-1] != src_a[DATA_W-1]);
    else if (alu_con == ALU_SUB)
      ovf = (src_a[DATA_W-1] != src_b[DATA_W-1]) && (alu_out[DATA_W-1] != src_a[DATA_W-1]);
  end

  // Register the flags alongside the ALU result
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      zero_p1 <= 1'b0;
      ovf_p1  <= 1'b0;
    end else begin
      zero_p1 <= zero;
      ovf_p1  <= ovf;
    end
  end

  assign zero_q = zero_p1;
  assign ovf_q  = ovf_p1;
`endif

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Self-checking bench for mips_exec_ctrl with a queue scoreboard on alu_q.
module tb_mips_exec_ctrl;

  localparam int DATA_W = 32;

  logic              clock;
  logic              reset_n;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [1:0]        aluop_in;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic [8:0]        ctrl;
  logic              brne, breq, andi, ori, addi, subi, in_out;
  logic [3:0]        alu_con;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] alu_q;
`ifdef MIPS_EXEC_FLAGS_EN
  logic              zero, ovf, zero_q, ovf_q;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] sb_q[$];
  logic [DATA_W-1:0] exp_v;
  logic [DATA_W-1:0] got_v;

  mips_exec_ctrl #(.DATA_W(DATA_W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .opcode   (opcode),
    .funct    (funct),
    .aluop_in (aluop_in),
    .src_a    (src_a),
    .src_b    (src_b),
    .ctrl     (ctrl),
    .brne     (brne),
    .breq     (breq),
    .andi     (andi),
    .ori      (ori),
    .addi     (addi),
    .subi     (subi),
    .in_out   (in_out),
    .alu_con  (alu_con),
    .alu_out  (alu_out),
`ifdef MIPS_EXEC_FLAGS_EN
    .zero     (zero),
    .ovf      (ovf),
    .zero_q   (zero_q),
    .ovf_q    (ovf_q),
`endif
    .alu_q    (alu_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: expected ALU op from ALUOp, funct and opcode
  function automatic logic [3:0] model_con(input logic [1:0] op, input logic [5:0] fn,
                                           input logic [5:0] opc);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b10) begin
      if (fn == 6'b100010) return 4'b0110;
      if (fn == 6'b100100) return 4'b0000;
      if (fn == 6'b100101) return 4'b0001;
      if (fn == 6'b100110) return 4'b0011;
      if (fn == 6'b100111) return 4'b1100;
      if (fn == 6'b101010) return 4'b0111;
      return 4'b0010;
    end
    if (opc == 6'b001100) return 4'b0000;
    if (opc == 6'b001101) return 4'b0001;
    if (opc == 6'b001001) return 4'b0110;
    return 4'b0010;
  endfunction

  // Reference model: expected ALU result
  function automatic logic [DATA_W-1:0] model_alu(input logic [3:0] c,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  // Drive one instruction at the falling edge and let decode settle
  task automatic drive(input logic [5:0] opc, input logic [5:0] fn, input logic [1:0] op,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    @(negedge clock);
    opcode = opc; funct = fn; aluop_in = op; src_a = a; src_b = b;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    opcode = 6'b100011; funct = 6'b0; aluop_in = 2'b00; src_a = 32'd2; src_b = 32'd3;
    @(posedge clock); #1;
    n_checks++;
    if (alu_q !== 32'd0) begin n_fail++; $display("FAIL reset_init alu_q got %h want 0", alu_q); end
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (alu_q !== 32'd5) begin n_fail++; $display("FAIL reset_run alu_q got %h want 5", alu_q); end
    // Assert reset mid-cycle: alu_q must clear without a clock edge
    @(negedge clock); #1; reset_n = 1'b0; #1;
    n_checks++;
    if (alu_q !== 32'd0) begin n_fail++; $display("FAIL reset_async alu_q got %h want 0", alu_q); end
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (alu_q !== 32'd5) begin n_fail++; $display("FAIL reset_release alu_q got %h want 5", alu_q); end
  endtask

  task automatic test_rtype();
    drive(6'b000000, 6'b100010, 2'b10, 32'd10, 32'd3);
    sb_q.push_back(32'd7);
    n_checks++;
    if (ctrl !== 9'h08A) begin n_fail++; $display("FAIL rtype_ctrl got %h want 08a", ctrl); end
    n_checks++;
    if (alu_con !== 4'b0110) begin n_fail++; $display("FAIL rtype_con got %b want 0110", alu_con); end
    n_checks++;
    if (alu_out !== 32'd7) begin n_fail++; $display("FAIL rtype_out got %h want 7", alu_out); end
    @(posedge clock); #1;
    exp_v = sb_q.pop_front();
    n_checks++;
    if (alu_q !== exp_v) begin n_fail++; $display("FAIL rtype_q got %h want %h", alu_q, exp_v); end
  endtask

  task automatic test_lw_in();
    drive(6'b100011, 6'b000000, 2'b00, 32'h100, 32'h4);
    n_checks++;
    if ({ctrl, in_out} !== {9'h1A4, 1'b0}) begin
      n_fail++; $display("FAIL lw_ctrl got %h/%b want 1a4/0", ctrl, in_out);
    end
    n_checks++;
    if ({alu_con, alu_out} !== {4'b0010, 32'h104}) begin
      n_fail++; $display("FAIL lw_alu got %b/%h want 0010/104", alu_con, alu_out);
    end
    drive(6'b111100, 6'b000000, 2'b00, 32'h100, 32'h4);
    n_checks++;
    if ({ctrl, in_out} !== {9'h1A4, 1'b1}) begin
      n_fail++; $display("FAIL in_ctrl got %h/%b want 1a4/1", ctrl, in_out);
    end
    drive(6'b101011, 6'b000000, 2'b00, 32'h0, 32'h0);
    n_checks++;
    if ({ctrl, in_out} !== {9'h014, 1'b0}) begin
      n_fail++; $display("FAIL sw_ctrl got %h/%b want 014/0", ctrl, in_out);
    end
    drive(6'b111101, 6'b000000, 2'b00, 32'h0, 32'h0);
    n_checks++;
    if ({ctrl, in_out} !== {9'h014, 1'b1}) begin
      n_fail++; $display("FAIL out_ctrl got %h/%b want 014/1", ctrl, in_out);
    end
  endtask

  task automatic test_immediates();
    logic [5:0] opcs [4];
    logic [6:0] flg  [4];
    logic [3:0] cons [4];
    logic [DATA_W-1:0] outs [4];
    opcs = '{6'b001101, 6'b001001, 6'b001100, 6'b001000};
    // flags ordered {brne,breq,andi,ori,addi,subi,in_out}
    flg  = '{7'b0001000, 7'b0000010, 7'b0010000, 7'b0000100};
    cons = '{4'b0001, 4'b0110, 4'b0000, 4'b0010};
    outs = '{32'hFF, 32'hE1, 32'h00, 32'hFF};
    for (int i = 0; i < 4; i++) begin
      drive(opcs[i], 6'b000000, 2'b11, 32'hF0, 32'h0F);
      n_checks++;
      if ({brne, breq, andi, ori, addi, subi, in_out} !== flg[i] || ctrl !== 9'h087) begin
        n_fail++;
        $display("FAIL imm_dec[%0d] flags %b ctrl %h want %b 087", i,
                 {brne, breq, andi, ori, addi, subi, in_out}, ctrl, flg[i]);
      end
      n_checks++;
      if ({alu_con, alu_out} !== {cons[i], outs[i]}) begin
        n_fail++;
        $display("FAIL imm_alu[%0d] got %b/%h want %b/%h", i, alu_con, alu_out, cons[i], outs[i]);
      end
    end
  endtask

  task automatic test_branch_slt();
    drive(6'b000101, 6'b000000, 2'b01, 32'd4, 32'd4);
    n_checks++;
    if ({ctrl, brne, breq} !== {9'h041, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL bne got %h/%b%b want 041/10", ctrl, brne, breq);
    end
    drive(6'b000100, 6'b000000, 2'b01, 32'd4, 32'd4);
    n_checks++;
    if ({ctrl, brne, breq, alu_out} !== {9'h041, 1'b0, 1'b1, 32'd0}) begin
      n_fail++; $display("FAIL beq got %h/%b%b/%h want 041/01/0", ctrl, brne, breq, alu_out);
    end
    drive(6'b000000, 6'b101010, 2'b10, 32'hFFFF_FFFF, 32'd1);
    n_checks++;
    if ({alu_con, alu_out} !== {4'b0111, 32'd1}) begin
      n_fail++; $display("FAIL slt_neg got %b/%h want 0111/1", alu_con, alu_out);
    end
    drive(6'b000000, 6'b101010, 2'b10, 32'd1, 32'hFFFF_FFFF);
    n_checks++;
    if (alu_out !== 32'd0) begin n_fail++; $display("FAIL slt_pos got %h want 0", alu_out); end
  endtask

  task automatic test_unknown();
    drive(6'b111111, 6'b000000, 2'b10, 32'd6, 32'd9);
    n_checks++;
    if ({ctrl, brne, breq, andi, ori, addi, subi, in_out} !== 16'd0) begin
      n_fail++; $display("FAIL unk_opcode got %h/%b want 0", ctrl,
                         {brne, breq, andi, ori, addi, subi, in_out});
    end
    n_checks++;
    if ({alu_con, alu_out} !== {4'b0010, 32'd15}) begin
      n_fail++; $display("FAIL unk_funct got %b/%h want 0010/f", alu_con, alu_out);
    end
    // ALUOp=11 with no immediate flag falls back to ADD
    drive(6'b111111, 6'b000000, 2'b11, 32'd6, 32'd9);
    n_checks++;
    if (alu_con !== 4'b0010) begin n_fail++; $display("FAIL unk_imm got %b want 0010", alu_con); end
  endtask

`ifdef MIPS_EXEC_FLAGS_EN
  task automatic test_flags();
    drive(6'b100011, 6'b000000, 2'b00, 32'h7FFF_FFFF, 32'd1);
    n_checks++;
    if ({ovf, zero} !== 2'b10) begin n_fail++; $display("FAIL flag_ovf got %b want 10", {ovf, zero}); end
    @(posedge clock); #1;
    n_checks++;
    if ({ovf_q, zero_q} !== 2'b10) begin n_fail++; $display("FAIL flag_q got %b want 10", {ovf_q, zero_q}); end
    drive(6'b000000, 6'b100010, 2'b10, 32'd5, 32'd5);
    n_checks++;
    if ({ovf, zero} !== 2'b01) begin n_fail++; $display("FAIL flag_zero got %b want 01", {ovf, zero}); end
    drive(6'b000000, 6'b100010, 2'b10, 32'h8000_0000, 32'd1);
    n_checks++;
    if (ovf !== 1'b1) begin n_fail++; $display("FAIL flag_subovf got %b want 1", ovf); end
    drive(6'b000000, 6'b100101, 2'b10, 32'h7FFF_FFFF, 32'd1);
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL flag_or got %b want 0", ovf); end
  endtask
`endif

  task automatic test_back_to_back();
    logic [5:0] fns [8];
    logic [1:0] op;
    logic [5:0] fn;
    logic [DATA_W-1:0] a, b;
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100110, 6'b100111, 6'b101010, 6'b000111};
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 2));
      fn = fns[$urandom_range(0, 7)];
      a  = $urandom();
      b  = $urandom();
      drive(6'b000000, fn, op, a, b);
      sb_q.push_back(model_alu(model_con(op, fn, 6'b000000), a, b));
      @(posedge clock); #1;
      if (sb_q.size() == 0) begin
        n_checks++; n_fail++; $display("FAIL b2b_empty at %0d", i);
      end else begin
        exp_v = sb_q.pop_front();
        got_v = alu_q;
        n_checks++;
        if (got_v !== exp_v) begin
          n_fail++;
          $display("FAIL b2b[%0d] op=%b fn=%b alu_q got %h want %h", i, op, fn, got_v, exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_in();
    test_immediates();
    test_branch_slt();
    test_unknown();
`ifdef MIPS_EXEC_FLAGS_EN
    test_flags();
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
